multi_port_lookup_array: RTL and testbench

Parametrised multi-port lookup array: a 2^ADDR_WIDTH × DATA_WIDTH memory with NUM_PORTS independent registered read ports and one write port. After reset it self-initialises to the identity pattern (entry i holds i) by sequentially sweeping every address. It then serves per-core table lookups in the multiprocessor. Firmware may overwrite entries or request a re-initialisation sweep at any time.

---
 rtl/multi_port_lookup_array_if.sv | 26 ++
 rtl/multi_port_lookup_array.sv | 117 +++++++++++
 tb/tb_multi_port_lookup_array.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/multi_port_lookup_array_if.sv
// Bus bundle for multi_port_lookup_array: control, per-port reads, write port.
interface multi_port_lookup_array_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                            Clear;
  logic                            Ready;
  logic [NUM_PORTS-1:0]            ReadEn;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] AddressBus;
  logic [NUM_PORTS*DATA_WIDTH-1:0] DataBus;
  logic [NUM_PORTS-1:0]            ReadValid;
  logic                            WriteEn;
  logic [ADDR_WIDTH-1:0]           WriteAddr;
  logic [DATA_WIDTH-1:0]           WriteData;

  modport master (
    output Clear, ReadEn, AddressBus, WriteEn, WriteAddr, WriteData,
    input  Ready, DataBus, ReadValid
  );

  modport slave (
    input  Clear, ReadEn, AddressBus, WriteEn, WriteAddr, WriteData,
    output Ready, DataBus, ReadValid
  );
endinterface

// File: rtl/multi_port_lookup_array.sv
// Multi-port lookup array: 2^ADDR_WIDTH x DATA_WIDTH table, NUM_PORTS
// registered read ports with write-first bypass, one write port, and a
// self-initialising identity sweep after reset or Clear.
module multi_port_lookup_array #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input logic                   clk,
  input logic                   reset,
  multi_port_lookup_array_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {INIT, RUN} state_e;

  state_e                               state_q, state_d;
  logic [ADDR_WIDTH-1:0]                init_addr_q, init_addr_d;
  logic [NUM_PORTS-1:0]                 valid_q, valid_d;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  run_accept;

  // User traffic is only accepted in RUN on an edge without Clear.
  always_comb begin
    rd_addr    = bus.AddressBus;
    run_accept = (state_q == RUN) && !bus.Clear;
  end

  // Sweep controller: next state and sweep address.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      INIT: begin
        if (bus.Clear) begin
          init_addr_d = '0;
        end else begin
          init_addr_d = init_addr_q + 1'b1;
          if (init_addr_q == '1) state_d = RUN;
        end
      end
      RUN: begin
        if (bus.Clear) begin
          state_d     = INIT;
          init_addr_d = '0;
        end
      end
      default: begin
        state_d     = INIT;
        init_addr_d = '0;
      end
    endcase
  end

  // Single memory write port, shared by the identity sweep and user writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_addr_q;
    mem_wdata = DATA_WIDTH'(init_addr_q);
    if (state_q == INIT && !bus.Clear) begin
      mem_we = 1'b1;
    end else if (run_accept && bus.WriteEn) begin
      mem_we    = 1'b1;
      mem_waddr = bus.WriteAddr;
      mem_wdata = bus.WriteData;
    end
  end

  // Per-port read with write-first bypass; idle ports hold their last data.
  always_comb begin
    valid_d = '0;
    data_d  = data_q;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (run_accept && bus.ReadEn[k]) begin
        valid_d[k] = 1'b1;
        if (bus.WriteEn && bus.WriteAddr == rd_addr[k]) begin
          data_d[k] = bus.WriteData;
        end else begin
          data_d[k] = mem_q[rd_addr[k]];
        end
      end
    end
  end

  // Table storage: deliberately not reset; contents are rebuilt by the sweep.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Control and read-port registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      init_addr_q <= '0;
      valid_q     <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
    end
  end

  // Output drive.
  always_comb begin
    bus.Ready     = (state_q == RUN);
    bus.ReadValid = valid_q;
    bus.DataBus   = data_q;
  end
endmodule

// File: tb/tb_multi_port_lookup_array.sv
// Directed bench for multi_port_lookup_array: default instance plus a
// narrow instance (2 ports, 16 x 3-bit) for the truncation case.
module tb_multi_port_lookup_array;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset_s = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  multi_port_lookup_array_if #(.NUM_PORTS(4), .ADDR_WIDTH(8), .DATA_WIDTH(8)) bus_m ();
  multi_port_lookup_array_if #(.NUM_PORTS(2), .ADDR_WIDTH(4), .DATA_WIDTH(3)) bus_s ();

  multi_port_lookup_array #(.NUM_PORTS(4), .ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m)
  );

  multi_port_lookup_array #(.NUM_PORTS(2), .ADDR_WIDTH(4), .DATA_WIDTH(3)) dut_s (
    .clk   (clk),
    .reset (reset_s),
    .bus   (bus_s)
  );

  typedef struct {
    logic [3:0]  ren;
    logic [31:0] addr;
    logic        wen;
    logic [7:0]  waddr;
    logic [7:0]  wdata;
    logic [3:0]  exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_m();
    bus_m.Clear      = 1'b0;
    bus_m.ReadEn     = '0;
    bus_m.AddressBus = '0;
    bus_m.WriteEn    = 1'b0;
    bus_m.WriteAddr  = '0;
    bus_m.WriteData  = '0;
  endtask

  task automatic apply(input vec_t v, input string name);
    bus_m.ReadEn     = v.ren;
    bus_m.AddressBus = v.addr;
    bus_m.WriteEn    = v.wen;
    bus_m.WriteAddr  = v.waddr;
    bus_m.WriteData  = v.wdata;
    @(posedge clk); #1;
    check({name, "_valid"}, 64'(bus_m.ReadValid), 64'(v.exp_valid));
    check({name, "_data"}, 64'(bus_m.DataBus), 64'(v.exp_data));
    idle_m();
  endtask

  // Counts edges until Ready on the default instance; optionally injects a
  // write + 4 reads while the sweep sits at address 5.
  task automatic sweep_m(input string name, input bit inject);
    int n = 0;
    int noisy = 0;
    while (bus_m.Ready !== 1'b1 && n < 2000) begin
      if (inject && n == 5) begin
        bus_m.WriteEn    = 1'b1;
        bus_m.WriteAddr  = 8'h05;
        bus_m.WriteData  = 8'h77;
        bus_m.ReadEn     = 4'hF;
        bus_m.AddressBus = 32'h05050505;
      end
      @(posedge clk); #1;
      n++;
      if (inject && n == 6) idle_m();
      if (bus_m.ReadValid !== 4'h0) noisy++;
    end
    check({name, "_edges"}, 64'(n), 64'd256);
    check({name, "_quiet"}, 64'(noisy), 64'd0);
  endtask

  initial begin
    vec_t v;
    int   n;
    int   noisy;

    vecs[0] = '{4'hF, 32'hFF7F0100, 1'b0, 8'h00, 8'h00, 4'hF, 32'hFF7F0100};
    vecs[1] = '{4'h4, 32'h00100000, 1'b1, 8'h10, 8'hA5, 4'h4, 32'hFFA50100};
    vecs[2] = '{4'h1, 32'h00000010, 1'b0, 8'h00, 8'h00, 4'h1, 32'hFFA501A5};
    vecs[3] = '{4'h2, 32'h00000500, 1'b0, 8'h00, 8'h00, 4'h2, 32'hFFA505A5};
    vecs[4] = '{4'hF, 32'h10101010, 1'b1, 8'h10, 8'h3C, 4'hF, 32'h3C3C3C3C};
    vecs[5] = '{4'h0, 32'h10101010, 1'b0, 8'h00, 8'h00, 4'h0, 32'h3C3C3C3C};
    vecs[6] = '{4'h8, 32'h21000000, 1'b1, 8'h20, 8'hFF, 4'h8, 32'h213C3C3C};
    vecs[7] = '{4'h1, 32'h00000020, 1'b0, 8'h00, 8'h00, 4'h1, 32'h213C3CFF};
    vecs[8] = '{4'hF, 32'h21051020, 1'b1, 8'h05, 8'h5A, 4'hF, 32'h215A3CFF};

    idle_m();
    bus_s.Clear      = 1'b0;
    bus_s.ReadEn     = '0;
    bus_s.AddressBus = '0;
    bus_s.WriteEn    = 1'b0;
    bus_s.WriteAddr  = '0;
    bus_s.WriteData  = '0;

    // Reset values while held in reset
    #12;
    check("rst_ready", 64'(bus_m.Ready), 64'd0);
    check("rst_valid", 64'(bus_m.ReadValid), 64'd0);
    check("rst_data", 64'(bus_m.DataBus), 64'd0);
    check("rst_s_ready", 64'(bus_s.Ready), 64'd0);
    #8 reset = 1'b1;

    // Sweep latency with dropped requests at sweep address 5
    sweep_m("sweep0", 1'b1);

    // RUN-mode reads, writes and bypass
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      apply(v, $sformatf("vec%0d", i));
    end

    // Clear in RUN with simultaneous traffic: nothing accepted
    check("pre_clear_ready", 64'(bus_m.Ready), 64'd1);
    bus_m.Clear      = 1'b1;
    bus_m.ReadEn     = 4'hF;
    bus_m.AddressBus = 32'h30303030;
    bus_m.WriteEn    = 1'b1;
    bus_m.WriteAddr  = 8'h30;
    bus_m.WriteData  = 8'h99;
    @(posedge clk); #1;
    idle_m();
    check("clear_ready", 64'(bus_m.Ready), 64'd0);
    check("clear_valid", 64'(bus_m.ReadValid), 64'd0);
    check("clear_hold", 64'(bus_m.DataBus), 64'h215A3CFF);
    sweep_m("sweep1", 1'b0);

    v = '{4'hF, 32'h10053020, 1'b0, 8'h00, 8'h00, 4'hF, 32'h10053020};
    apply(v, "post_clear");

    // Reset mid-sweep at InitAddr=100
    bus_m.Clear = 1'b1;
    @(posedge clk); #1;
    bus_m.Clear = 1'b0;
    noisy = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus_m.Ready !== 1'b0 || bus_m.ReadValid !== 4'h0) noisy++;
    end
    check("midsweep_quiet", 64'(noisy), 64'd0);
    reset = 1'b0;
    #1;
    check("arst_ready", 64'(bus_m.Ready), 64'd0);
    check("arst_valid", 64'(bus_m.ReadValid), 64'd0);
    check("arst_data", 64'(bus_m.DataBus), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    sweep_m("sweep2", 1'b0);
    v = '{4'h1, 32'h00000020, 1'b0, 8'h00, 8'h00, 4'h1, 32'h00000020};
    apply(v, "post_arst");

    // Narrow instance: 16-entry sweep, 3-bit truncation, shared address
    reset_s = 1'b1;
    n = 0;
    while (bus_s.Ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("s_edges", 64'(n), 64'd16);
    bus_s.ReadEn     = 2'b11;
    bus_s.AddressBus = 8'h7D;
    @(posedge clk); #1;
    check("s_trunc_valid", 64'(bus_s.ReadValid), 64'd3);
    check("s_trunc_data", 64'(bus_s.DataBus), 64'h3D);
    bus_s.AddressBus = 8'h77;
    @(posedge clk); #1;
    check("s_same_valid", 64'(bus_s.ReadValid), 64'd3);
    check("s_same_data", 64'(bus_s.DataBus), 64'h3F);
    bus_s.ReadEn = 2'b00;
    @(posedge clk); #1;
    check("s_idle_valid", 64'(bus_s.ReadValid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
